// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit CPU.
// Drives the IR/PC/MAR/ACC strobes and the memory handshake, with a memory wait timeout.
module control_sequencer #(
    parameter int word_size   = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] ir_in,
    input  logic                 mem_ready,
    input  logic                 zero_flag,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 mar_sel,
    output logic                 mar_load,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 acc_load,
    output logic [1:0]           alu_op,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_M = 3'd1,
        DECODE  = 3'd2,
        EXEC_A  = 3'd3,
        EXEC_M  = 3'd4,
        HALT    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     cur_state;
    logic [7:0] wait_cnt;
    logic [3:0] opcode;
    logic       is_sta;
    logic       timeout;

    assign opcode = ir_in[word_size-1 -: 4];
    assign is_sta = (opcode == OP_STA);
    // The cycle that would complete MEM_TIMEOUT waits without a ready faults instead.
    assign timeout = !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= FETCH_A;
            wait_cnt  <= 8'd0;
        end else begin
            unique case (cur_state)
                FETCH_A: begin
                    cur_state <= FETCH_M;
                    wait_cnt  <= 8'd0;
                end
                FETCH_M: begin
                    if (mem_ready) begin
                        cur_state <= DECODE;
                        wait_cnt  <= 8'd0;
                    end else if (timeout) begin
                        cur_state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: cur_state <= EXEC_A;
                        OP_HLT:                         cur_state <= HALT;
                        default:                        cur_state <= FETCH_A;
                    endcase
                end
                EXEC_A: begin
                    cur_state <= EXEC_M;
                    wait_cnt  <= 8'd0;
                end
                EXEC_M: begin
                    if (mem_ready) begin
                        cur_state <= FETCH_A;
                        wait_cnt  <= 8'd0;
                    end else if (timeout) begin
                        cur_state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT:    cur_state <= HALT;
                FAULT:   cur_state <= FAULT;
                default: cur_state <= FETCH_A;
            endcase
        end
    end

    // Strobes decode from the state register; all are forced low while rst is held.
    always_comb begin
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_sel  = 1'b0;
        mar_load = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        acc_load = 1'b0;
        alu_op   = 2'b00;
        halted   = 1'b0;
        fault    = 1'b0;
        state    = 3'd0;
        if (!rst) begin
            state = cur_state;
            unique case (cur_state)
                FETCH_A: mar_load = 1'b1;
                FETCH_M: begin
                    mem_rd  = 1'b1;
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                DECODE: begin
                    pc_load = (opcode == OP_JMP) ||
                              ((opcode == OP_JZ) && zero_flag);
                end
                EXEC_A: begin
                    mar_sel  = 1'b1;
                    mar_load = 1'b1;
                end
                EXEC_M: begin
                    mem_wr   = is_sta;
                    mem_rd   = !is_sta;
                    acc_load = mem_ready && !is_sta;
                    case (opcode)
                        OP_ADD:  alu_op = 2'b01;
                        OP_SUB:  alu_op = 2'b10;
                        default: alu_op = 2'b00;
                    endcase
                end
                HALT: halted = 1'b1;
                FAULT: begin
                    halted = 1'b1;
                    fault  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
